// File: rtl/sop_mod_q_param.sv
// Sum-of-products modulo Q: out = (sum_j x_j * C[mode][j]) mod Q.
// Ping-pong residue banks, loadable coefficient table and a valid/ready result port.
module sop_mod_q_param #(
    parameter int unsigned     W     = 30,
    parameter int unsigned     N     = 7,
    parameter longint unsigned Q     = 64'd1068564481,
    parameter int unsigned     MODES = 2
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    coef_we,
    input  logic [((MODES > 1) ? $clog2(MODES) : 1)-1:0] coef_mode,
    input  logic [$clog2(N)-1:0]                    coef_addr,
    input  logic [W-1:0]                            coef_data,
    input  logic [((MODES > 1) ? $clog2(MODES) : 1)-1:0] mode,
    input  logic                                    data_in_valid,
    input  logic [$clog2(N)-1:0]                    data_in_address,
    input  logic [W-1:0]                            data_in,
    output logic                                    in_ready,
    output logic                                    data_out_valid,
    output logic [W-1:0]                            data_out,
    input  logic                                    data_out_ready,
    output logic                                    err_overflow
);

    localparam int unsigned AW    = $clog2(N);
    localparam int unsigned MW    = (MODES > 1) ? $clog2(MODES) : 1;
    localparam int unsigned ACC_W = 2 * W + $clog2(N);
    localparam int unsigned R     = ACC_W - W + 1;
    localparam int unsigned RCW   = $clog2(R);

    localparam logic [AW-1:0]    LAST  = AW'(N - 1);
    localparam logic [RCW-1:0]   RLAST = RCW'(R - 1);
    localparam logic [W-1:0]     QW    = W'(Q);
    // Largest reduction step: Q << (R-1) still fits in ACC_W bits.
    localparam logic [ACC_W-1:0] Q_TOP = {{(ACC_W - W){1'b0}}, QW} << (R - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_MAC  = 3'd2;
    localparam logic [2:0] ST_RED  = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     bank_q [2][N];
    logic [W-1:0]     coef_q [MODES][N];
    logic [MW-1:0]    bank_mode_q [2];
    logic [1:0]       full_q;
    logic             wr_bank_q, rd_bank_q;
    logic [AW-1:0]    rd_idx_q, mac_cnt_q;
    logic [RCW-1:0]   red_cnt_q;
    logic [W-1:0]     x_q, c_q, data_out_q;
    logic [ACC_W-1:0] acc_q, q_sh_q, red_acc;
    logic [2*W-1:0]   prod;
    logic             err_q, wr_ok, commit, release_bank, coef_ok;

    assign in_ready       = ~(full_q[0] & full_q[1]);
    assign data_out_valid = (state_q == ST_OUT);
    assign data_out       = data_out_q;
    assign err_overflow   = err_q;

    assign wr_ok        = data_in_valid && in_ready && (32'(data_in_address) < N);
    assign commit       = wr_ok && (data_in_address == LAST);
    assign release_bank = (state_q == ST_MAC) && (mac_cnt_q == LAST);
    assign coef_ok      = coef_we && (state_q == ST_IDLE) && (full_q == 2'b00) &&
                          (32'(coef_addr) < N) && (32'(coef_mode) < MODES);

    always_comb begin
        prod    = {{W{1'b0}}, x_q} * {{W{1'b0}}, c_q};
        red_acc = (acc_q >= q_sh_q) ? (acc_q - q_sh_q) : acc_q;
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (full_q[rd_bank_q]) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_MAC;
            ST_MAC:  if (mac_cnt_q == LAST) state_d = ST_RED;
            ST_RED:  if (red_cnt_q == RLAST) state_d = ST_OUT;
            ST_OUT:  if (data_out_ready) state_d = full_q[~rd_bank_q] ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Residue storage needs no reset; the full flags qualify its contents.
    always_ff @(posedge clock) begin
        if (wr_ok) bank_q[wr_bank_q][data_in_address] <= data_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            mac_cnt_q   <= '0;
            red_cnt_q   <= '0;
            x_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            q_sh_q      <= '0;
            data_out_q  <= '0;
            err_q       <= 1'b0;
            bank_mode_q <= '{default: '0};
            for (int m = 0; m < MODES; m++) begin
                for (int j = 0; j < N; j++) coef_q[m][j] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (release_bank) full_q[rd_bank_q] <= 1'b0;
            if (commit) begin
                full_q[wr_bank_q]      <= 1'b1;
                bank_mode_q[wr_bank_q] <= mode;
                wr_bank_q              <= ~wr_bank_q;
            end
            if (data_in_valid && !in_ready) err_q <= 1'b1;
            if (coef_ok) coef_q[coef_mode][coef_addr] <= coef_data;

            // One-cycle read pipeline: term j is fetched the cycle before it is accumulated.
            if (state_q == ST_LOAD || state_q == ST_MAC) begin
                x_q      <= bank_q[rd_bank_q][rd_idx_q];
                c_q      <= coef_q[bank_mode_q[rd_bank_q]][rd_idx_q];
                rd_idx_q <= (rd_idx_q == LAST) ? '0 : rd_idx_q + 1'b1;
            end else begin
                rd_idx_q <= '0;
            end

            case (state_q)
                ST_LOAD: begin
                    acc_q     <= '0;
                    mac_cnt_q <= '0;
                end
                ST_MAC: begin
                    acc_q     <= acc_q + {{(ACC_W - 2 * W){1'b0}}, prod};
                    mac_cnt_q <= mac_cnt_q + 1'b1;
                    if (mac_cnt_q == LAST) begin
                        q_sh_q    <= Q_TOP;
                        red_cnt_q <= '0;
                    end
                end
                ST_RED: begin
                    acc_q     <= red_acc;
                    q_sh_q    <= q_sh_q >> 1;
                    red_cnt_q <= red_cnt_q + 1'b1;
                    if (red_cnt_q == RLAST) data_out_q <= red_acc[W-1:0];
                end
                ST_OUT: if (data_out_ready) rd_bank_q <= ~rd_bank_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sop_mod_q_param.sv
// Directed bench for sop_mod_q_param: hand-computed results, latency, backpressure, overflow, reset.
module tb_sop_mod_q_param;

    localparam int W = 30;
    localparam int N = 7;
    localparam longint unsigned Q = 64'd1068564481;
    localparam int LAT = 43;  // N + R + 2 with R = (2*30+3) - 30 + 1 = 34

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          coef_we = 1'b0;
    logic [0:0]    coef_mode = '0;
    logic [2:0]    coef_addr = '0;
    logic [W-1:0]  coef_data = '0;
    logic [0:0]    mode = '0;
    logic          data_in_valid = 1'b0;
    logic [2:0]    data_in_address = '0;
    logic [W-1:0]  data_in = '0;
    logic          in_ready;
    logic          data_out_valid;
    logic [W-1:0]  data_out;
    logic          data_out_ready = 1'b1;
    logic          err_overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cnt = 0;

    sop_mod_q_param dut (
        .clock          (clock),
        .reset          (reset),
        .coef_we        (coef_we),
        .coef_mode      (coef_mode),
        .coef_addr      (coef_addr),
        .coef_data      (coef_data),
        .mode           (mode),
        .data_in_valid  (data_in_valid),
        .data_in_address(data_in_address),
        .data_in        (data_in),
        .in_ready       (in_ready),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .data_out_ready (data_out_ready),
        .err_overflow   (err_overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (data_out_valid && data_out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // C[m][j] = base + mul*j
    task automatic load_coefs(input int m, input longint unsigned base, input longint unsigned mul);
        for (int j = 0; j < N; j++) begin
            @(negedge clock);
            coef_we   = 1'b1;
            coef_mode = 1'(m);
            coef_addr = 3'(j);
            coef_data = W'(base + mul * longint'(j));
        end
        @(negedge clock);
        coef_we = 1'b0;
    endtask

    // x_j = base + mul*j, gapless; commit_cyc is the cycle count after the committing edge.
    task automatic write_block(input int m, input longint unsigned base,
                               input longint unsigned mul, output int commit_cyc,
                               output int drops);
        drops = 0;
        for (int j = 0; j < N; j++) begin
            @(negedge clock);
            if (!in_ready) drops++;
            data_in_valid   = 1'b1;
            data_in_address = 3'(j);
            data_in         = W'(base + mul * longint'(j));
            mode            = 1'(m);
        end
        commit_cyc = cyc + 1;
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        data_in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [W-1:0] val, output int at, output bit ok);
        ok  = 1'b0;
        val = '0;
        at  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (data_out_valid) begin
                val = data_out;
                at  = cyc;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [W-1:0] v1, v2;
        int t1, t2, a1, a2, d, hs0, bad, seen;
        bit ok;

        do_reset();
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_valid", data_out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_ovf", err_overflow, 0);

        // T1: C[0]=1, x=j+1 -> 28 with fixed latency
        load_coefs(0, 1, 0);
        write_block(0, 1, 1, t1, d);
        idle_inputs();
        check("t1_drops", d, 0);
        wait_result(v1, a1, ok);
        check("t1_seen", ok, 1);
        check("t1_data", v1, 28);
        check("t1_latency", a1 - t1, LAT);

        // T2: all (Q-1)*(Q-1) -> N mod Q
        load_coefs(0, Q - 1, 0);
        write_block(0, Q - 1, 0, t1, d);
        idle_inputs();
        wait_result(v1, a1, ok);
        check("t2_seen", ok, 1);
        check("t2_data", v1, 7);

        // T3: C[1][j]=j, C[0][j]=0, x=2^29
        load_coefs(1, 0, 1);
        load_coefs(0, 0, 0);
        write_block(1, 64'd536870912, 0, t1, d);
        idle_inputs();
        wait_result(v1, a1, ok);
        check("t3_mode1", v1, 64'd588644342);
        write_block(0, 64'd536870912, 0, t1, d);
        idle_inputs();
        wait_result(v1, a1, ok);
        check("t3_mode0", v1, 0);

        // T4: three gapless blocks
        do_reset();
        load_coefs(0, 1, 0);
        write_block(0, 1, 1, t1, d);
        write_block(0, 10, 10, t2, d);
        write_block(0, 5, 0, a2, d);
        idle_inputs();
        check("t4_dropped", d != 0, 1);
        check("t4_ovf", err_overflow, 1);
        wait_result(v1, a1, ok);
        check("t4_first", v1, 28);
        check("t4_first_lat", a1 - t1, LAT);
        wait_result(v2, a2, ok);
        check("t4_second", v2, 280);
        check("t4_gap", a2 - a1, LAT);

        // T5: backpressure for 20 cycles
        do_reset();
        load_coefs(0, 1, 0);
        data_out_ready = 1'b0;
        write_block(0, 1, 1, t1, d);
        idle_inputs();
        wait_result(v1, a1, ok);
        check("t5_seen", ok, 1);
        hs0 = hs_cnt;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!data_out_valid || data_out !== v1) bad++;
        end
        check("t5_hold", bad, 0);
        check("t5_data", data_out, 28);
        data_out_ready = 1'b1;
        @(negedge clock);
        check("t5_valid_drop", data_out_valid, 0);
        repeat (5) @(negedge clock);
        check("t5_handshakes", hs_cnt - hs0, 1);

        // T6: reset pulse in the middle of reduction
        do_reset();
        load_coefs(1, 0, 1);
        write_block(1, 1, 1, t1, d);
        idle_inputs();
        repeat (25) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("t6_in_ready", in_ready, 1);
        check("t6_valid", data_out_valid, 0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (data_out_valid) seen++;
        end
        check("t6_no_result", seen, 0);
        write_block(1, 1, 1, t1, d);
        idle_inputs();
        wait_result(v1, a1, ok);
        check("t6_coef_cleared", v1, 0);
        load_coefs(0, 1, 0);
        write_block(0, 1, 1, t1, d);
        idle_inputs();
        wait_result(v1, a1, ok);
        check("t6_after", v1, 28);
        check("t6_after_lat", a1 - t1, LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
